// File: rtl/seq_mult32_pkg.sv
// Shared types and helpers for the iterative 32x32 multiplier.
package seq_mult32_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_CALC,
        ST_FIX,
        ST_DONE
    } state_t;

    localparam int MUL_ITER = 32;

    function automatic logic [31:0] neg32(input logic [31:0] x);
        return ~x + 32'd1;
    endfunction

    // 0x8000_0000 maps to itself and is then treated as unsigned 2^31.
    function automatic logic [31:0] abs32(input logic [31:0] x);
        return x[31] ? neg32(x) : x;
    endfunction

endpackage

// File: rtl/seq_mult32_ripcarryadder.sv
// Plain ripple-carry adder: sum = a + b + cin, with carry out.
module ripcarryadder #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    logic [WIDTH:0] carry;

    assign carry[0] = cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign sum[i]     = a[i] ^ b[i] ^ carry[i];
        assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end

    assign cout = carry[WIDTH];

endmodule

// File: rtl/seq_mult32.sv
// Iterative shift-add 32x32->64 multiplier, signed or unsigned, one partial
// product per cycle; sign applied by a 64-bit negate in FIX.
module seq_mult32
    import seq_mult32_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               is_signed,
    input  logic [WIDTH-1:0]   op_a,
    input  logic [WIDTH-1:0]   op_b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    // Handshake: start is accepted on any rising edge where the FSM is in IDLE
    // or DONE; operands are captured on that edge. done is a one-cycle pulse,
    // never coincident with busy; product holds until the next FIX.
    state_t             state, state_nx;
    logic [WIDTH-1:0]   mcand, hi, lo;
    logic               neg;
    logic [CNT_W-1:0]   cnt;
    logic               accept;

    logic [WIDTH-1:0]   add0_a, add0_b, add0_sum;
    logic               add0_cin, add0_cout;
    logic [WIDTH-1:0]   add1_sum;
    logic               add1_cout;

    assign accept = start && (state == ST_IDLE || state == ST_DONE);
    assign busy   = (state == ST_LOAD) || (state == ST_CALC) || (state == ST_FIX);
    assign done   = (state == ST_DONE);

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: if (start) state_nx = ST_LOAD;
            ST_LOAD: state_nx = ST_CALC;
            ST_CALC: if (cnt == CNT_W'(MUL_ITER - 1)) state_nx = ST_FIX;
            ST_FIX:  state_nx = ST_DONE;
            ST_DONE: state_nx = start ? ST_LOAD : ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    // Adder 0 accumulates in CALC and negates the low word in FIX.
    always_comb begin
        add0_a   = hi;
        add0_b   = lo[0] ? mcand : '0;
        add0_cin = 1'b0;
        if (state == ST_FIX) begin
            add0_a   = ~lo;
            add0_b   = '0;
            add0_cin = 1'b1;
        end
    end

    ripcarryadder #(.WIDTH(WIDTH)) u_add_lo (
        .a    (add0_a),
        .b    (add0_b),
        .cin  (add0_cin),
        .sum  (add0_sum),
        .cout (add0_cout)
    );

    // High-word negate; its carry out is set only when {hi,lo} is zero.
    ripcarryadder #(.WIDTH(WIDTH)) u_add_hi (
        .a    (~hi),
        .b    ('0),
        .cin  (add0_cout),
        .sum  (add1_sum),
        .cout (add1_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            mcand   <= '0;
            hi      <= '0;
            lo      <= '0;
            neg     <= 1'b0;
            cnt     <= '0;
            product <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                mcand <= is_signed ? abs32(op_a) : op_a;
                lo    <= is_signed ? abs32(op_b) : op_b;
                neg   <= is_signed && (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
                hi    <= '0;
                cnt   <= '0;
            end else if (state == ST_CALC) begin
                hi  <= {add0_cout, add0_sum[WIDTH-1:1]};
                lo  <= {add0_sum[0], lo[WIDTH-1:1]};
                cnt <= cnt + 1'b1;
            end else if (state == ST_FIX) begin
                product <= (neg && !add1_cout) ? {add1_sum, add0_sum} : {hi, lo};
            end
        end
    end

endmodule
